// File: rtl/sram_req_arbiter.sv
// Arbitrates the fetch (inst) and memory (data) masters onto one SRAM-like bus and
// routes in-order responses back by owner. Define ARB_RR_EN for round-robin tie-breaking.
module sram_req_arbiter #(
    parameter int OT_DEPTH = 2,
    parameter int OT_W     = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_req,
    input  logic               inst_wr,
    input  logic [1:0]         inst_size,
    input  logic [3:0]         inst_wstrb,
    input  logic [31:0]        inst_addr,
    input  logic [31:0]        inst_wdata,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    output logic [31:0]        inst_rdata,
    input  logic               data_req,
    input  logic               data_wr,
    input  logic [1:0]         data_size,
    input  logic [3:0]         data_wstrb,
    input  logic [31:0]        data_addr,
    input  logic [31:0]        data_wdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    output logic [31:0]        data_rdata,
    output logic               s_req,
    output logic               s_wr,
    output logic [1:0]         s_size,
    output logic [3:0]         s_wstrb,
    output logic [31:0]        s_addr,
    output logic [31:0]        s_wdata,
    input  logic               s_addr_ok,
    input  logic               s_data_ok,
    input  logic [31:0]        s_rdata,
    output logic [OT_W:0]      ot_cnt,
    output logic               rsp_err
);

    localparam logic [OT_W:0]   OT_FULL_C   = (OT_W + 1)'(OT_DEPTH);
    localparam logic [OT_W:0]   CNT_ONE_C   = (OT_W + 1)'(1);
    localparam logic [OT_W:0]   CNT_ZERO_C  = (OT_W + 1)'(0);
    localparam logic [OT_W-1:0] PTR_ONE_C   = OT_W'(1);
    localparam logic [OT_W-1:0] PTR_ZERO_C  = OT_W'(0);

    logic [OT_DEPTH-1:0] owner_mem_r;
    logic [OT_W-1:0]     head_r;
    logic [OT_W-1:0]     tail_r;
    logic [OT_W:0]       ot_cnt_r;
    logic                lock_r;
    logic                lock_owner_r;
    logic                rsp_err_r;
`ifdef ARB_RR_EN
    logic                last_grant_r;
`endif

    logic sel_owner_s;
    logic sel_req_s;
    logic full_s;
    logic empty_s;
    logic req_valid_s;
    logic push_s;
    logic pop_s;
    logic head_owner_s;

    // Owner selection: a held (locked) request always keeps the bus
    always_comb begin
        sel_owner_s = 1'b0;
        if (lock_r) begin
            sel_owner_s = lock_owner_r;
`ifdef ARB_RR_EN
        end else if (data_req && inst_req) begin
            sel_owner_s = ~last_grant_r;
`endif
        end else if (data_req) begin
            sel_owner_s = 1'b1;
        end else begin
            sel_owner_s = 1'b0;
        end
    end

    assign sel_req_s    = sel_owner_s ? data_req : inst_req;
    assign full_s       = (ot_cnt_r == OT_FULL_C);
    assign empty_s      = (ot_cnt_r == CNT_ZERO_C);
    // full uses the registered count only, so s_data_ok never feeds s_req
    assign req_valid_s  = sel_req_s & ~full_s & ~reset;
    assign push_s       = req_valid_s & s_addr_ok;
    assign pop_s        = s_data_ok & ~empty_s;
    assign head_owner_s = owner_mem_r[head_r];

    // Bus-side request mux and master-side handshakes, forced quiet in reset
    always_comb begin
        s_req        = 1'b0;
        s_wr         = 1'b0;
        s_size       = 2'b00;
        s_wstrb      = 4'b0000;
        s_addr       = 32'h0000_0000;
        s_wdata      = 32'h0000_0000;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'h0000_0000;
        data_rdata   = 32'h0000_0000;
        if (reset) begin
            s_req = 1'b0;
        end else begin
            s_req        = req_valid_s;
            s_wr         = sel_owner_s ? data_wr    : inst_wr;
            s_size       = sel_owner_s ? data_size  : inst_size;
            s_wstrb      = sel_owner_s ? data_wstrb : inst_wstrb;
            s_addr       = sel_owner_s ? data_addr  : inst_addr;
            s_wdata      = sel_owner_s ? data_wdata : inst_wdata;
            inst_addr_ok = push_s & ~sel_owner_s;
            data_addr_ok = push_s & sel_owner_s;
            inst_data_ok = pop_s & ~head_owner_s;
            data_data_ok = pop_s & head_owner_s;
            inst_rdata   = s_rdata;
            data_rdata   = s_rdata;
        end
    end

    // Owner FIFO storage and pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_mem_r <= {OT_DEPTH{1'b0}};
            head_r      <= PTR_ZERO_C;
            tail_r      <= PTR_ZERO_C;
        end else begin
            if (push_s) begin
                owner_mem_r[tail_r] <= sel_owner_s;
                tail_r              <= tail_r + PTR_ONE_C;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE_C;
            end
        end
    end

    // Outstanding count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ot_cnt_r <= CNT_ZERO_C;
        end else begin
            case ({push_s, pop_s})
                2'b10:   ot_cnt_r <= ot_cnt_r + CNT_ONE_C;
                2'b01:   ot_cnt_r <= ot_cnt_r - CNT_ONE_C;
                default: ot_cnt_r <= ot_cnt_r;
            endcase
        end
    end

    // Hold a presented-but-unaccepted request until the bus accepts it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_r       <= 1'b0;
            lock_owner_r <= 1'b0;
        end else if (push_s) begin
            lock_r <= 1'b0;
        end else if (req_valid_s && !s_addr_ok) begin
            lock_r       <= 1'b1;
            lock_owner_r <= sel_owner_s;
        end
    end

    // Sticky flag for a response arriving with nothing outstanding
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err_r <= 1'b0;
        end else if (s_data_ok && empty_s) begin
            rsp_err_r <= 1'b1;
        end
    end

`ifdef ARB_RR_EN
    // Most recently accepted owner, used to alternate ties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_r <= 1'b0;
        end else if (push_s) begin
            last_grant_r <= sel_owner_s;
        end
    end
`endif

    assign ot_cnt  = ot_cnt_r;
    assign rsp_err = rsp_err_r;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_sram_req_arbiter;

    localparam int OT_DEPTH = 2;
    localparam int OT_W     = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic [OT_W:0] ot_cnt;
    logic        rsp_err;

    sram_req_arbiter #(.OT_DEPTH(OT_DEPTH), .OT_W(OT_W)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .ot_cnt(ot_cnt), .rsp_err(rsp_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding owners in acceptance order, plus hold/grant history
    bit m_q[$];
    bit sb_q[$];
    bit m_lock, m_lock_owner, m_last, m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_wstrb = 4'h0;
        inst_addr = 32'h0; inst_wdata = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'h0;
        data_addr = 32'h0; data_wdata = 32'h0;
        s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
    endtask

    // One bus cycle: inputs are already driven (posedge+1); check at posedge+4
    task automatic step();
        bit full, sel, sreq, acc, pop, head;
        #3;
        full = (m_q.size() == OT_DEPTH);
        if (m_lock) begin
            sel = m_lock_owner;
        end else if (inst_req && data_req) begin
`ifdef ARB_RR_EN
            sel = !m_last;
`else
            sel = 1'b1;
`endif
        end else begin
            sel = data_req;
        end
        sreq = (sel ? data_req : inst_req) && !full;
        acc  = sreq && s_addr_ok;
        pop  = s_data_ok && (m_q.size() != 0);
        head = (m_q.size() != 0) ? m_q[0] : 1'b0;

        chk("s_req", s_req, sreq);
        if (sreq) begin
            chk("s_addr", s_addr, sel ? data_addr : inst_addr);
            chk("s_ctl_wdata", {s_wr, s_size, s_wstrb, s_wdata},
                sel ? {data_wr, data_size, data_wstrb, data_wdata}
                    : {inst_wr, inst_size, inst_wstrb, inst_wdata});
        end
        chk("addr_ok", {inst_addr_ok, data_addr_ok}, {acc && !sel, acc && sel});
        chk("data_ok", {inst_data_ok, data_data_ok}, {pop && !head, pop && head});
        chk("ot_cnt", ot_cnt, m_q.size());
        chk("rsp_err", rsp_err, m_err);

        if (s_data_ok && m_q.size() == 0) m_err = 1'b1;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            m_q.push_back(sel);
            sb_q.push_back(sel);
            m_last = sel;
            m_lock = 1'b0;
        end else if (sreq && !s_addr_ok) begin
            m_lock       = 1'b1;
            m_lock_owner = sel;
        end

        @(posedge clk);
        #1;
        if (acc && !sel) inst_req = 1'b0;
        if (acc && sel)  data_req = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h1234_5678;
        s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'hA5A5_5A5A;
        #2;
        chk("rst_s_req", s_req, 1'b0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        chk("rst_rdata", {inst_rdata, data_rdata}, 64'h0);
        chk("rst_ot_cnt", ot_cnt, 0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        m_q.delete(); sb_q.delete();
        m_lock = 1'b0; m_lock_owner = 1'b0; m_last = 1'b0; m_err = 1'b0;
        @(posedge clk);
        #1;
        idle();
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every response the DUT presents must match the oldest accept
    initial begin
        bit own;
        forever begin
            @(negedge clk);
            if (inst_data_ok || data_data_ok) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: data_ok %b%b with nothing expected at %0t",
                             inst_data_ok, data_data_ok, $time);
                end else begin
                    own = sb_q.pop_front();
                    chk("sb_owner", {inst_data_ok, data_data_ok}, own ? 2'b01 : 2'b10);
                    chk("sb_rdata", own ? data_rdata : inst_rdata, s_rdata);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        do_reset();

        // single inst read
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; inst_size = 2'd2; inst_wstrb = 4'hF;
        s_addr_ok = 1'b1;
        step();
        s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h0280_0C05;
        step();

        // contention, second tie, then full stall and drain with push+pop
        s_data_ok = 1'b0; s_addr_ok = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h1C00_0040;
        data_req = 1'b1; data_addr = 32'h1C00_8000; data_wr = 1'b1; data_wdata = 32'hCAFE_0001;
        step();
        data_req = 1'b1; data_addr = 32'h1C00_8004;
        step();
        step();
        s_data_ok = 1'b1; s_rdata = 32'h1111_2222;
        step();
        s_rdata = 32'h3333_4444;
        step();
        s_rdata = 32'h5555_6666;
        step();
        s_data_ok = 1'b0;
        step();

        // lock: inst held while the bus stalls, data arrives mid-stall
        idle();
        inst_req = 1'b1; inst_addr = 32'h1C00_0100;
        step();
        data_req = 1'b1; data_addr = 32'h1C00_8100;
        step();
        step();
        s_addr_ok = 1'b1;
        step();
        step();
        s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h7777_8888;
        step();
        s_rdata = 32'h9999_AAAA;
        step();

        // spurious response sets a sticky error, cleared only by reset
        idle();
        s_data_ok = 1'b1;
        step();
        s_data_ok = 1'b0;
        step();
        step();
        do_reset();

        // randomized traffic with a well-behaved slave and holding masters
        for (int c = 0; c < 3000; c++) begin
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req   = 1'b1;
                inst_wr    = 1'b0;
                inst_size  = 2'($urandom_range(0, 2));
                inst_wstrb = 4'($urandom);
                inst_addr  = $urandom;
                inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req   = 1'b1;
                data_wr    = 1'($urandom_range(0, 1));
                data_size  = 2'($urandom_range(0, 2));
                data_wstrb = 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            s_addr_ok = 1'($urandom_range(0, 1));
            s_data_ok = (m_q.size() != 0) ? 1'($urandom_range(0, 1))
                                           : ($urandom_range(0, 49) == 0);
            s_rdata   = $urandom;
            step();
            if (c % 500 == 499) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
- Shares one SRAM-like bus (req/addr_ok/data_ok handshake) between the fetch-stage master (inst) and the memory-stage master (data).
- Grants address phases, holds a granted request stable until it is accepted, and records the owner of each accepted request in an in-order FIFO.
- Routes each returning data_ok/rdata to the master that owns it.
- Sits between the IF/EX-MEM stages and the AXI bridge.

Parameters:
- OT_DEPTH, 2, maximum accepted-but-unanswered requests (power of 2, ≥2)
- OT_W, 1, log2(OT_DEPTH); width of the FIFO pointers

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  inst master request
- inst_wr  in  1  write flag (tied 0 by fetch, still forwarded)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_wstrb  in  4  byte strobes
- inst_addr  in  32  address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  inst address phase accepted
- inst_data_ok  out  1  inst response valid
- inst_rdata  out  32  inst read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  data master request fields, same meaning as inst_*
- data_addr_ok  out  1  data address phase accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  32  data read data
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1/1/2/4/32/32  shared bus request fields
- s_addr_ok  in  1  shared bus address accepted
- s_data_ok  in  1  shared bus response valid
- s_rdata  in  32  shared bus read data
- ot_cnt  out  OT_W+1  current outstanding count
- rsp_err  out  1  sticky: s_data_ok seen with FIFO empty

Behaviour:
- Reset: all FIFO entries and pointers are 0, ot_cnt=0, lock=0, lock_owner=0, rsp_err=0. All outputs are 0 while reset is high.
- Owner encoding: 0=inst, 1=data.
- Arbitration (combinational, zero latency):
  - full = (ot_cnt==OT_DEPTH).
  - If lock=1, the selected owner is lock_owner.
  - Otherwise data wins when data_req=1; inst wins when only inst_req=1.
  - s_req = selected master's req & ~full. All s_* request fields are muxed from the selected master.
- Accept (push) = s_req & s_addr_ok.
  - The selected master's addr_ok = s_addr_ok & s_req; the other master's addr_ok=0.
  - On push, the owner is written at the FIFO tail and the tail increments, wrapping mod OT_DEPTH.
- Lock:
  - Set: if s_req=1 and s_addr_ok=0 at a clock edge, then next cycle lock=1 and lock_owner=selected owner.
  - Clear: lock clears on the edge where accept occurs.
  - Effect: a presented request is never pre-empted, so its s_* fields stay stable until addr_ok.
  - If full stalls a master, s_req=0 and no lock is set.
- Response (pop) = s_data_ok & (ot_cnt!=0).
  - The head owner selects which master gets data_ok=1. Both masters' rdata = s_rdata; the non-owner's data_ok=0.
  - Head increments on pop, wrapping.
  - If s_data_ok=1 while ot_cnt==0: no data_ok to either master, rsp_err set (sticky until reset).
- Simultaneous push and pop in one cycle: ot_cnt unchanged; both pointers advance.
  - When full, a same-cycle pop does not enable a push; s_req stays 0 that cycle (no combinational path from s_data_ok to s_req).
- Responses are returned strictly in acceptance order. A push and a pop for the same master in one cycle are legal.
- Reset asserted mid-transaction: state clears immediately (async). Any later s_data_ok for a pre-reset request is treated as the empty case and sets rsp_err; the bridge is reset together with this block, so this does not occur in normal operation.

Optional Feature:
- ARB_RR_EN
- Defined: when both reqs are high and lock=0, the winner alternates. A last_grant register (reset 0=inst, so data wins first) updates on each accept to the accepted owner; the next tie goes to the other master.
- Undefined: fixed data-over-inst priority as above, and no last_grant register exists.

Test Plan:
1. Single inst read: inst_req=1, addr=0x1C000000, s_addr_ok=1 in same cycle -> inst_addr_ok=1, ot_cnt 0->1; next cycle s_data_ok=1, s_rdata=0x02800C05 -> inst_data_ok=1, inst_rdata=0x02800C05, ot_cnt=0.
2. Contention: inst_req=data_req=1, data_addr=0x1C008000, s_addr_ok=1 -> s_addr=0x1C008000, data_addr_ok=1, inst_addr_ok=0; next cycle inst granted. With ARB_RR_EN, on a second tie the master opposite last_grant wins.
3. Lock: inst_req=1 with s_addr_ok=0 for 3 cycles, data_req rises in cycle 2 -> s_addr stays inst_addr in all cycles until accept; data is granted only after the inst accept.
4. Full: OT_DEPTH=2, accept inst then data with no response -> ot_cnt=2, s_req=0 despite inst_req=1. Then s_data_ok -> inst_data_ok=1 (in order); the following cycle s_req=1.
5. Push+pop same cycle with ot_cnt=1: accept data while s_data_ok returns the inst response -> inst_data_ok=1, data_addr_ok=1, ot_cnt stays 1.
6. Spurious response: ot_cnt=0, s_data_ok=1 -> no data_ok out, rsp_err=1 and stays 1; async reset pulse -> rsp_err=0, ot_cnt=0, lock=0.
